mem_access_unit: RTL and testbench

//  Parametrised MEM pipeline stage with a req/gnt/rvalid handshake to variable-latency data memory.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: load/store type codes, MEM FSM states and access-size helpers
package mem_pkg;
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LD  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [2:0] LT_LWU = 3'b110;
  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;
  localparam logic [1:0] ST_SD  = 2'b11;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DRAIN} state_e;
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return 8'((16'd1 << (4'd1 << sz)) - 16'd1);
  endfunction
  function automatic logic [1:0] ld_size(input logic [2:0] lt, input logic wide);
    return (lt == LT_LB || lt == LT_LBU) ? 2'd0 :
           (lt == LT_LH || lt == LT_LHU) ? 2'd1 :
           (lt == LT_LW || lt == LT_LWU) ? 2'd2 :
           (lt == LT_LD && wide) ? 2'd3 : 2'd2;
  endfunction
  function automatic logic [1:0] st_size(input logic [1:0] st, input logic wide);
    return st == ST_SB ? 2'd0 : st == ST_SH ? 2'd1 : st == ST_SW ? 2'd2 :
           (st == ST_SD && wide) ? 2'd3 : 2'd2;
  endfunction
  function automatic logic ld_unsigned(input logic [2:0] lt);
    return lt == LT_LBU || lt == LT_LHU || lt == LT_LWU;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane replication/byte enables, load extract/extend, misalignment flag (MEM_MISALIGN_TRAP_EN)
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OW = (XLEN == 64) ? 3 : 2,
  localparam int BW = XLEN / 8
) (
  input  logic [OW-1:0]   off,
  input  logic            is_load,
  input  logic [2:0]      lt,
  input  logic [1:0]      st,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      ld_lt,
  input  logic [OW-1:0]   ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [BW-1:0]   be,
  output logic [XLEN-1:0] ld_data,
  output logic [1:0]      sz,
  output logic            mis
);
  localparam logic WIDE = (XLEN == 64);
  logic [1:0] ssz, lsz;
  logic [OW-1:0] aoff, ld_aoff;
  logic [XLEN-1:0] v, km;
  logic sgn;
  always_comb begin
    ssz = st_size(st, WIDE);
    sz = is_load ? ld_size(lt, WIDE) : ssz;
    aoff = off & ~OW'((4'd1 << sz) - 4'd1);
    wdata = ssz == 2'd0 ? {BW{rs2[7:0]}} : ssz == 2'd1 ? {(XLEN/16){rs2[15:0]}} :
            ssz == 2'd2 ? {(XLEN/32){rs2[31:0]}} : rs2;
    be = is_load ? '1 : BW'(size_mask(sz)) << aoff;
    lsz = ld_size(ld_lt, WIDE);
    ld_aoff = ld_off & ~OW'((4'd1 << lsz) - 4'd1);
    v = rdata >> {ld_aoff, 3'b000};
    km = (XLEN'(1) << (8 << lsz)) - XLEN'(1);
    sgn = ~ld_unsigned(ld_lt) & (lsz == 2'd0 ? v[7] : lsz == 2'd1 ? v[15] : v[31]);
    ld_data = (v & km) | ({XLEN{sgn}} & ~km);
  end
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = |(off & OW'((4'd1 << sz) - 4'd1));
`else
  assign mis = 1'b0;
`endif
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage with req/gnt/rvalid dmem handshake and registered MEM/WB output (MEM_MISALIGN_TRAP_EN traps misaligned accesses)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [XLEN-1:0]     in_rs2_data,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  input  logic [2:0]          in_load_type,
  input  logic [1:0]          in_store_type,
  input  logic                in_wb_reg,
  input  logic                in_memtoreg,
  output logic                stall_out,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [XLEN/8-1:0]   dmem_be,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic                wb_we,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_exc
);
  localparam int OW = (XLEN == 64) ? 3 : 2;
  state_e state_q, state_d;
  logic [RD_W-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [2:0] lt_q, lt_d;
  logic [OW-1:0] off_q, off_d;
  logic wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, wb_exc_q, wb_exc_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d, ld_data;
  logic [1:0] sz;
  logic mis, mem_op, done, exc;
  mem_lane_align #(.XLEN(XLEN)) u_align (
    .off(in_alu_result[OW-1:0]), .is_load(in_mem_read), .lt(in_load_type), .st(in_store_type),
    .rs2(in_rs2_data), .ld_lt(lt_q), .ld_off(off_q), .rdata(dmem_rdata),
    .wdata(dmem_wdata), .be(dmem_be), .ld_data(ld_data), .sz(sz), .mis(mis)
  );
  assign dmem_addr = ADDR_W'(in_alu_result) & ~ADDR_W'((4'd1 << sz) - 4'd1);
  assign dmem_we = dmem_req & in_mem_write;
  always_comb begin
    mem_op = in_valid & (in_mem_read | in_mem_write);
    state_d = state_q;
    rd_d = rd_q;
    lt_d = lt_q;
    off_d = off_q;
    dmem_req = 1'b0;
    done = 1'b0;
    exc = 1'b0;
    stall_out = 1'b1;
    unique case (state_q)
      IDLE, REQ: begin
        state_d = IDLE;
        if (flush) stall_out = 1'b0;
        else if (!mem_op || mis) begin
          done = in_valid;
          exc = mem_op;
          stall_out = 1'b0;
        end else begin
          dmem_req = 1'b1;
          if (!dmem_gnt) state_d = REQ;
          else if (in_mem_write) begin
            done = 1'b1;
            stall_out = 1'b0;
          end else begin
            state_d = WAIT_R;
            rd_d = in_rd;
            lt_d = in_load_type;
            off_d = in_alu_result[OW-1:0];
          end
        end
      end
      WAIT_R: begin
        if (flush) state_d = dmem_rvalid ? IDLE : DRAIN;
        else if (dmem_rvalid) begin
          state_d = IDLE;
          done = 1'b1;
          stall_out = 1'b0;
        end
      end
      DRAIN: state_d = dmem_rvalid ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    wb_valid_d = done;
    wb_we_d = done & ~exc & in_wb_reg;
    wb_exc_d = done & exc;
    wb_rd_d = !done ? wb_rd_q : state_q == WAIT_R ? rd_q : in_rd;
    wb_data_d = !done ? wb_data_q : (state_q == WAIT_R && in_memtoreg) ? ld_data : in_alu_result;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q <= '0;
      lt_q <= '0;
      off_q <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q <= 1'b0;
      wb_exc_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      lt_q <= lt_d;
      off_q <= off_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q <= wb_we_d;
      wb_exc_q <= wb_exc_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end
  assign wb_valid = wb_valid_q;
  assign wb_we = wb_we_q;
  assign wb_exc = wb_exc_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] in_alu_result = '0, in_rs2_data = '0, dmem_rdata = '0;
  logic [4:0] in_rd = '0;
  logic in_mem_read = 1'b0, in_mem_write = 1'b0, in_wb_reg = 1'b0, in_memtoreg = 1'b0;
  logic [2:0] in_load_type = '0;
  logic [1:0] in_store_type = '0;
  logic dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic stall_out, dmem_req, dmem_we, wb_valid, wb_we, wb_exc;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0] dmem_be;
  logic [4:0] wb_rd;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_access_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_rs2_data(in_rs2_data), .in_rd(in_rd), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_load_type(in_load_type), .in_store_type(in_store_type), .in_wb_reg(in_wb_reg),
    .in_memtoreg(in_memtoreg), .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_data(wb_data), .wb_exc(wb_exc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 1'b0;
    in_mem_read = 1'b0;
    in_mem_write = 1'b0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    flush = 1'b0;
  endtask
  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] lt,
                    input logic [1:0] st, input logic [31:0] d);
    in_valid = 1'b1;
    in_mem_read = rd;
    in_mem_write = wr;
    in_alu_result = a;
    in_load_type = lt;
    in_store_type = st;
    in_rs2_data = d;
    in_rd = 5'd9;
    in_wb_reg = ~wr;
    in_memtoreg = rd;
  endtask
  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] lt,
                      input logic [31:0] rdat, input logic [31:0] exp);
    op(1'b1, 1'b0, a, lt, 2'b00, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    chk({tag, ".req"}, {31'b0, dmem_req}, 32'd1);
    tick();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = rdat;
    #1;
    tick();
    chk({tag, ".data"}, wb_data, exp);
    idle();
  endtask
  initial begin
    int req_n, st_n;
    repeat (2) tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rst.stall", {31'b0, stall_out}, 32'd0);
    chk("rst.req", {31'b0, dmem_req}, 32'd0);
    chk("rst.wbv", {31'b0, wb_valid}, 32'd0);
    chk("rst.we", {31'b0, wb_we}, 32'd0);
    chk("rst.data", wb_data, 32'd0);
    tick();
    op(1'b0, 1'b0, 32'h55, 3'b000, 2'b00, 32'h0);
    in_rd = 5'd3;
    #1;
    chk("alu.stall", {31'b0, stall_out}, 32'd0);
    chk("alu.req", {31'b0, dmem_req}, 32'd0);
    tick();
    chk("alu.wbv", {31'b0, wb_valid}, 32'd1);
    chk("alu.data", wb_data, 32'h55);
    chk("alu.rd", {27'b0, wb_rd}, 32'd3);
    chk("alu.we", {31'b0, wb_we}, 32'd1);
    idle();
    tick();
    chk("bub.wbv", {31'b0, wb_valid}, 32'd0);
    chk("bub.we", {31'b0, wb_we}, 32'd0);
    op(1'b1, 1'b0, 32'h100, 3'b010, 2'b00, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    chk("lw.req", {31'b0, dmem_req}, 32'd1);
    chk("lw.we", {31'b0, dmem_we}, 32'd0);
    chk("lw.addr", dmem_addr, 32'h100);
    chk("lw.be", {28'b0, dmem_be}, 32'hf);
    chk("lw.stall", {31'b0, stall_out}, 32'd1);
    tick();
    chk("lw.wbv0", {31'b0, wb_valid}, 32'd0);
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw.req2", {31'b0, dmem_req}, 32'd0);
    chk("lw.stall2", {31'b0, stall_out}, 32'd0);
    tick();
    chk("lw.wbv", {31'b0, wb_valid}, 32'd1);
    chk("lw.data", wb_data, 32'hDEADBEEF);
    chk("lw.we1", {31'b0, wb_we}, 32'd1);
    chk("lw.rd", {27'b0, wb_rd}, 32'd9);
    idle();
    load("lb3", 32'h103, 3'b000, 32'h80FFFF7F, 32'hFFFFFF80);
    load("lbu3", 32'h103, 3'b100, 32'h80FFFF7F, 32'h00000080);
    load("lh2", 32'h102, 3'b001, 32'h80FFFF7F, 32'hFFFF80FF);
    load("lhu2", 32'h102, 3'b101, 32'h80FFFF7F, 32'h000080FF);
    load("lb0", 32'h100, 3'b000, 32'h80FFFF7F, 32'h0000007F);
    load("lh0", 32'h100, 3'b001, 32'h80FFFF7F, 32'hFFFFFF7F);
    load("lwu", 32'h104, 3'b110, 32'h80000001, 32'h80000001);
    op(1'b0, 1'b1, 32'h102, 3'b000, 2'b01, 32'hABCD1234);
    req_n = 0;
    st_n = 0;
    for (int k = 0; k < 4; k++) begin
      dmem_gnt = (k == 3);
      #1;
      if (k == 0) begin
        chk("sh.be", {28'b0, dmem_be}, 32'hc);
        chk("sh.wd", {16'b0, dmem_wdata[31:16]}, 32'h1234);
        chk("sh.addr", dmem_addr, 32'h102);
        chk("sh.we", {31'b0, dmem_we}, 32'd1);
      end
      req_n += int'(dmem_req);
      st_n += int'(stall_out);
      tick();
    end
    chk("sh.reqs", req_n, 32'd4);
    chk("sh.stalls", st_n, 32'd3);
    chk("sh.wbv", {31'b0, wb_valid}, 32'd1);
    chk("sh.wbwe", {31'b0, wb_we}, 32'd0);
    idle();
    op(1'b0, 1'b1, 32'h101, 3'b000, 2'b00, 32'h000000AB);
    dmem_gnt = 1'b1;
    #1;
    chk("sb.be", {28'b0, dmem_be}, 32'h2);
    chk("sb.wd", dmem_wdata, 32'hABABABAB);
    tick();
    chk("sb.wbv", {31'b0, wb_valid}, 32'd1);
    op(1'b0, 1'b1, 32'h104, 3'b000, 2'b10, 32'h13579BDF);
    #1;
    chk("sw.be", {28'b0, dmem_be}, 32'hf);
    chk("sw.wd", dmem_wdata, 32'h13579BDF);
    tick();
    idle();
    op(1'b1, 1'b0, 32'h200, 3'b010, 2'b00, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_gnt = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl.stall", {31'b0, stall_out}, 32'd1);
    tick();
    chk("fl.wbv", {31'b0, wb_valid}, 32'd0);
    flush = 1'b0;
    op(1'b1, 1'b0, 32'h300, 3'b010, 2'b00, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    chk("dr.req", {31'b0, dmem_req}, 32'd0);
    chk("dr.stall", {31'b0, stall_out}, 32'd1);
    tick();
    chk("dr.wbv", {31'b0, wb_valid}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h11111111;
    #1;
    chk("dr.req2", {31'b0, dmem_req}, 32'd0);
    chk("dr.stall2", {31'b0, stall_out}, 32'd1);
    tick();
    chk("dr.wbv2", {31'b0, wb_valid}, 32'd0);
    dmem_rvalid = 1'b0;
    #1;
    chk("nx.req", {31'b0, dmem_req}, 32'd1);
    chk("nx.addr", dmem_addr, 32'h300);
    tick();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h22222222;
    #1;
    tick();
    chk("nx.wbv", {31'b0, wb_valid}, 32'd1);
    chk("nx.data", wb_data, 32'h22222222);
    idle();
    op(1'b1, 1'b0, 32'h400, 3'b010, 2'b00, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h33333333;
    flush = 1'b1;
    #1;
    tick();
    chk("kill.wbv", {31'b0, wb_valid}, 32'd0);
    idle();
    op(1'b0, 1'b0, 32'h77, 3'b000, 2'b00, 32'h0);
    #1;
    chk("kill.stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("kill.next", wb_data, 32'h77);
    op(1'b1, 1'b0, 32'h500, 3'b010, 2'b00, 32'h0);
    #1;
    tick();
    flush = 1'b1;
    #1;
    chk("freq.req", {31'b0, dmem_req}, 32'd0);
    tick();
    chk("freq.wbv", {31'b0, wb_valid}, 32'd0);
    idle();
    op(1'b1, 1'b0, 32'h101, 3'b010, 2'b00, 32'h0);
    dmem_gnt = 1'b1;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis.req", {31'b0, dmem_req}, 32'd0);
    chk("mis.stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("mis.wbv", {31'b0, wb_valid}, 32'd1);
    chk("mis.we", {31'b0, wb_we}, 32'd0);
    chk("mis.exc", {31'b0, wb_exc}, 32'd1);
`else
    chk("mis.addr", dmem_addr, 32'h100);
    chk("mis.req", {31'b0, dmem_req}, 32'd1);
    tick();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    tick();
    chk("mis.data", wb_data, 32'hCAFEF00D);
    chk("mis.exc", {31'b0, wb_exc}, 32'd0);
`endif
    idle();
    op(1'b1, 1'b0, 32'h600, 3'b010, 2'b00, 32'h0);
    dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    idle();
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h99;
    #1;
    chk("rs.stall", {31'b0, stall_out}, 32'd0);
    chk("rs.req", {31'b0, dmem_req}, 32'd0);
    tick();
    chk("rs.wbv", {31'b0, wb_valid}, 32'd0);
    idle();
    op(1'b0, 1'b0, 32'h42, 3'b000, 2'b00, 32'h0);
    #1;
    chk("rs.alu.stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("rs.alu.wbv", {31'b0, wb_valid}, 32'd1);
    chk("rs.alu.data", wb_data, 32'h42);
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
